// File: rtl/sprite_draw_ctrl_if.sv
// Sprite draw controller bus bundle.
// Purpose: groups the start/done handshake, the sprite RAM read port and the
// VGA pixel-write port into one interface.
// Modports:
//   master - environment side (game FSM, sprite RAM, VGA adapter):
//            drives start/erase/base_x/base_y/rom_data, observes the rest
//   slave  - the controller itself (sprite_draw_ctrl)
// Signals:
//   start, erase, base_x[7:0], base_y[6:0]  draw request and its parameters
//   busy, done                              draw status
//   rom_addr[9:0], rom_data[15:0]           sprite RAM read port
//   vga_x[7:0], vga_y[6:0], vga_colour[2:0], plot   pixel write port
interface sprite_draw_ctrl_if;
    logic        start;
    logic        erase;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;

    modport master (
        output start, erase, base_x, base_y, rom_data,
        input  busy, done, rom_addr, vga_x, vga_y, vga_colour, plot
    );

    modport slave (
        input  start, erase, base_x, base_y, rom_data,
        output busy, done, rom_addr, vga_x, vga_y, vga_colour, plot
    );
endinterface

// File: rtl/sprite_draw_ctrl.sv
// Sprite draw controller.
// Purpose: on start, walks sprite entries from address 0, offsets each entry
// by the base position latched at start, clips to the screen, drops
// transparent pixels and issues one-cycle plot strobes. Three cycles per
// entry (READ, WAIT, PLOT); the walk ends at the entry with more=0 or at
// address DEPTH-1, followed by a one-cycle done pulse.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - sprite_draw_ctrl_if.slave (handshake, sprite RAM, VGA port)
// Entry format in rom_data: {x[15:10], y[9:4], colour[3:1], more[0]}.
module sprite_draw_ctrl #(
    parameter int          DEPTH       = 800,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter logic [2:0]  TRANSPARENT = 3'b000,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input logic               clk,
    input logic               reset,
    sprite_draw_ctrl_if.slave bus
);

    localparam logic [9:0] LAST_ADDR    = 10'(DEPTH - 1);
    localparam logic [8:0] SCREEN_W_LIM = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_H_LIM = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PLOT,
        DONE
    } state_t;

    state_t      state_reg,  state_next;
    logic [9:0]  addr_reg,   addr_next;
    logic [7:0]  base_x_reg, base_x_next;
    logic [6:0]  base_y_reg, base_y_next;
    logic        erase_reg,  erase_next;
    logic [7:0]  vga_x_reg,  vga_x_next;
    logic [6:0]  vga_y_reg,  vga_y_next;
    logic [2:0]  colour_reg, colour_next;
    logic        plot_reg,   plot_next;
    logic        last_reg,   last_next;
    logic        busy_reg,   busy_next;
    logic        done_reg,   done_next;

    // Entry fields and screen-space position of the entry being fetched.
    logic [5:0]  entry_x;
    logic [5:0]  entry_y;
    logic [2:0]  entry_colour;
    logic        entry_more;
    logic [8:0]  sx;
    logic [7:0]  sy;
    logic        vis;

    assign entry_x      = bus.rom_data[15:10];
    assign entry_y      = bus.rom_data[9:4];
    assign entry_colour = bus.rom_data[3:1];
    assign entry_more   = bus.rom_data[0];

    // One extra bit keeps the sum from wrapping back onto the screen.
    assign sx  = {1'b0, base_x_reg} + {3'b000, entry_x};
    assign sy  = {1'b0, base_y_reg} + {2'b00, entry_y};
    assign vis = (sx < SCREEN_W_LIM) && (sy < SCREEN_H_LIM)
                 && (entry_colour != TRANSPARENT);

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        base_x_next = base_x_reg;
        base_y_next = base_y_reg;
        erase_next  = erase_reg;
        vga_x_next  = vga_x_reg;
        vga_y_next  = vga_y_reg;
        colour_next = colour_reg;
        last_next   = last_reg;
        busy_next   = busy_reg;
        plot_next   = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    base_x_next = bus.base_x;
                    base_y_next = bus.base_y;
                    erase_next  = bus.erase;
                    addr_next   = '0;
                    busy_next   = 1'b1;
                    state_next  = READ;
                end
            end
            // Address is held through READ and WAIT so a registered-read RAM
            // has its data ready by the WAIT exit edge.
            READ: begin
                state_next = WAIT;
            end
            WAIT: begin
                vga_x_next  = sx[7:0];
                vga_y_next  = sy[6:0];
                colour_next = erase_reg ? BG_COLOUR : entry_colour;
                plot_next   = vis;
                last_next   = !entry_more || (addr_reg == LAST_ADDR);
                state_next  = PLOT;
            end
            PLOT: begin
                if (last_reg) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + 10'd1;
                    state_next = READ;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            base_x_reg <= '0;
            base_y_reg <= '0;
            erase_reg  <= 1'b0;
            vga_x_reg  <= '0;
            vga_y_reg  <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            last_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            base_x_reg <= base_x_next;
            base_y_reg <= base_y_next;
            erase_reg  <= erase_next;
            vga_x_reg  <= vga_x_next;
            vga_y_reg  <= vga_y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            last_reg   <= last_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.rom_addr   = addr_reg;
    assign bus.vga_x      = vga_x_reg;
    assign bus.vga_y      = vga_y_reg;
    assign bus.vga_colour = colour_reg;
    assign bus.plot       = plot_reg;

endmodule

// File: doc/sprite_draw_ctrl.md
Name: sprite_draw_ctrl

Overview:
Sequences one full sprite draw from the sprite RAM into the VGA pixel-write interface. On `start`, it walks sprite entries from address 0. Each 16-bit entry is {x[5:0], y[5:0], colour[2:0], more}. The controller offsets each entry by a latched screen base position, clips it to the 160x120 screen, drops transparent pixels, and issues single-cycle plot strobes. It sits between the game-logic FSM (start/done handshake) and the shared sprite RAM plus VGA adapter.

Parameters:
DEPTH, 800, number of sprite entries; the last address walked is DEPTH-1.
SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are suppressed.
SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are suppressed.
TRANSPARENT, 3'b000, colour value never plotted.
BG_COLOUR, 3'b000, colour emitted for all plotted pixels in erase mode.

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
start  input  1  request a draw; accepted only in IDLE
erase  input  1  sampled with start; 1 = paint BG_COLOUR over the sprite footprint
base_x  input  8  screen x of sprite origin; sampled with start
base_y  input  7  screen y of sprite origin; sampled with start
busy  output  1  high from the accept edge until return to IDLE
done  output  1  one-cycle pulse, draw complete
rom_addr  output  10  sprite RAM read address
rom_data  input  16  sprite RAM read data {x[15:10], y[9:4], colour[3:1], more[0]}
vga_x  output  8  pixel x
vga_y  output  7  pixel y
vga_colour  output  3  pixel colour
plot  output  1  pixel write strobe, one cycle per plotted pixel

Behaviour:
- Reset (sync, priority over everything): state=IDLE, busy=0, done=0, plot=0, rom_addr=0, vga_x=0, vga_y=0, vga_colour=0. Reset mid-draw aborts with no done pulse; plot is 0 in the cycle after the reset edge.
- States: IDLE, READ, WAIT, PLOT, DONE. All outputs are registered.
- IDLE: at an edge with start=1:
  - latch base_x, base_y, erase;
  - rom_addr<=0, busy<=1, go to READ.
  - start=0: stay in IDLE.
- READ -> WAIT unconditionally. rom_addr is held stable through READ and WAIT, so RAM with either combinational read or 1-cycle registered read is valid.
- WAIT: at the exit edge, sample rom_data and compute sx = base_x + x (9-bit) and sy = base_y + y (8-bit).
  - vis = (sx < SCREEN_W) && (sy < SCREEN_H) && (colour != TRANSPARENT).
  - Register vga_x=sx[7:0], vga_y=sy[6:0], vga_colour = erase ? BG_COLOUR : colour, plot=vis, last=(more==0)||(rom_addr==DEPTH-1).
  - Go to PLOT.
- PLOT: plot is high for exactly this cycle if vis.
  - At the exit edge, plot<=0.
  - If last: go to DONE.
  - Otherwise: rom_addr<=rom_addr+1 and go to READ.
- DONE: done=1 and busy=1 for one cycle, then IDLE with done<=0 and busy<=0.
- The entry carrying more=0 is itself drawn. rom_addr never exceeds DEPTH-1 and never wraps.
- Timing, with the accept edge as edge 0: entry k is plotted in the cycle after edge 3k+2. For N entries, done is high in the cycle after edge 3N; the block is back in IDLE (busy=0) after edge 3N+1.
- start while busy (any state other than IDLE) is ignored and not queued. start held high through DONE is accepted at the first IDLE edge.
- Changes to base_x, base_y or erase during a draw have no effect.

Test Plan:
- RAM with 800 entries (x=i%20, y=i/20, colour=3'b101, more=1 except entry 799 more=0); base=(10,20); pulse start -> 800 plots; the first is (10,20,5) after edge 2, the last is (29,59,5); done is high only after edge 2400; busy=0 after edge 2401.
- Same RAM, base=(150,100) -> only pixels with sx<160 and sy<120 are plotted (10 columns x 20 rows = 200 plots); timing is unchanged; done still after edge 2400.
- Entry 5 has more=0 and entries 2 and 3 have colour 000 -> 4 plots (entries 0, 1, 4, 5); done after edge 18.
- erase=1 at start with the full RAM -> 800 plots, all with vga_colour=000 at the same coordinates as the first scenario.
- start pulsed again at edge 100 with different base values -> ignored; coordinates are unaffected; exactly one done pulse.
- reset asserted at edge 50 mid-draw -> plot=0, busy=0 and rom_addr=0 after that edge; no done pulse; a new start then draws correctly from entry 0.
